popcount_pipe: RTL and testbench



---
 rtl/popcount_pkg.sv | 27 ++
 rtl/popcount_pipe_if.sv | 32 +++
 rtl/popcount_tree_level.sv | 34 +++
 rtl/popcount_pipe.sv | 121 ++++++++++++
 tb/tb_popcount_pipe.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// Shared constants and elaboration-time helpers for the streaming popcount engine.
package popcount_pkg;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

  // Result width able to hold 0..w inclusive.
  function automatic int clog2_plus1(input int w);
    return $clog2(w + 1);
  endfunction

  // Adder-tree leaf count: WIDTH rounded up to a power of two.
  function automatic int pad_pow2(input int w);
    return 1 << $clog2(w);
  endfunction

  // Bit offset of tree level k inside the flattened tree bus; level j is (p2>>j) fields of j+1 bits.
  function automatic int level_offset(input int p2, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off += (p2 >> j) * (j + 1);
    end
    return off;
  endfunction

endpackage

// File: rtl/popcount_pipe_if.sv
// Beat-in / result-out stream bundle; slave is the engine side, master is the driving/consuming side.
interface popcount_pipe_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 12
);
  import popcount_pkg::*;

  localparam int CNT_W = clog2_plus1(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [ACC_W-1:0] out_acc;
  logic             out_last;
  logic             out_sat;

  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_count, out_acc, out_last, out_sat
  );

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_acc, out_last, out_sat
  );

endinterface

// File: rtl/popcount_tree_level.sv
// One registered adder-tree level: N_IN operands of OPW bits -> N_IN/2 sums of OPW+1 bits.
// Latency 1 cycle; holds its register while en is low.
module popcount_tree_level #(
  parameter int N_IN = 2,
  parameter int OPW  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [N_IN*OPW-1:0]            in_sum,
  output logic [(N_IN/2)*(OPW+1)-1:0]    out_sum
);

  localparam int N_OUT = N_IN / 2;
  localparam int SW    = OPW + 1;

  logic [N_OUT*SW-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sum_d[i*SW +: SW] = SW'(in_sum[(2*i)*OPW +: OPW]) + SW'(in_sum[(2*i+1)*OPW +: OPW]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum <= '0;
    end else if (en) begin
      out_sum <= sum_d;
    end
  end

endmodule

// File: rtl/popcount_pipe.sv
// Streaming ones/zeros counter with saturating per-packet total; latency $clog2(P2)+1 cycles.
// Global stall: in_ready = !out_valid || out_ready, every stage freezes while the result is refused.
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 12
) (
  input logic            clk,
  input logic            rst_n,
  popcount_pipe_if.slave bus
);

  localparam int CNT_W = clog2_plus1(WIDTH);
  localparam int P2    = pad_pow2(WIDTH);
  localparam int L     = $clog2(P2);
  localparam int TBW   = level_offset(P2, L + 1);
  localparam int OFF_L = level_offset(P2, L);
  localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

  logic             adv;
  logic             rdy_en;
  logic             take;
  logic [WIDTH-1:0] in_word;
  logic [P2-1:0]    d_q;
  logic [L:0]       vld_q;
  logic [L:0]       last_q;
  logic [TBW-1:0]   tree_bus;
  logic [L:0]       tree_sum;
  logic             unused_sum_bits;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_next;
  logic             sat_q;
  logic             sat_hit;
  logic             sat_next;

  assign adv          = !vld_q[L] || bus.out_ready;
  assign bus.in_ready = adv && rdy_en;
  assign take         = bus.in_valid && bus.in_ready;

  // Inversion happens before padding so pad bits stay zero in zeros mode.
  assign in_word = (bus.in_mode == MODE_ZEROS) ? ~bus.in_data : bus.in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Bubbles load zero data so an idle slot contributes nothing downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      vld_q  <= '0;
      last_q <= '0;
    end else if (adv) begin
      d_q    <= take ? P2'(in_word) : '0;
      vld_q  <= {vld_q[L-1:0], take};
      last_q <= {last_q[L-1:0], take && bus.in_last};
    end
  end

  assign tree_bus[P2-1:0] = d_q;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int N_IN  = P2 >> (k - 1);
    localparam int OFF_I = level_offset(P2, k - 1);
    localparam int OFF_O = level_offset(P2, k);

    popcount_tree_level #(
      .N_IN (N_IN),
      .OPW  (k)
    ) u_lvl (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .in_sum  (tree_bus[OFF_I +: N_IN*k]),
      .out_sum (tree_bus[OFF_O +: (N_IN/2)*(k+1)])
    );
  end

  // The tree sum never exceeds WIDTH, so any bits above CNT_W are always zero.
  assign tree_sum        = tree_bus[OFF_L +: L+1];
  assign unused_sum_bits = ^tree_sum;
  assign cnt             = CNT_W'(tree_sum);

  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(cnt);

  always_comb begin
    sat_hit  = (acc_sum > ACC_MAX);
    acc_next = sat_hit ? ACC_MAX[ACC_W-1:0] : acc_sum[ACC_W-1:0];
    sat_next = sat_q || sat_hit;
  end

  // acc_q holds the total of results already accepted in the current packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (vld_q[L] && bus.out_ready) begin
      if (last_q[L]) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else begin
        acc_q <= acc_next;
        sat_q <= sat_next;
      end
    end
  end

  assign bus.out_valid = vld_q[L];
  assign bus.out_last  = last_q[L];
  assign bus.out_count = cnt;
  assign bus.out_acc   = acc_next;
  assign bus.out_sat   = sat_next;

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench: three popcount_pipe instances (16/12, 13/12, 16/5) fed the same stream, checked against a packet model.
module tb_popcount_pipe;

  typedef struct {
    int cnt;
    int acc;
    bit last;
    bit sat;
    int tag;
    int cyc;
  } exp_t;

  typedef struct {
    int cnt;
    int acc;
    bit sat;
    bit last;
  } lit_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_mode;
  logic        in_last;
  logic        out_ready;
  logic        bp;
  logic        done;
  int          tag;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  popcount_pipe_if #(.WIDTH(16), .ACC_W(12)) if16 ();
  popcount_pipe_if #(.WIDTH(13), .ACC_W(12)) if13 ();
  popcount_pipe_if #(.WIDTH(16), .ACC_W(5))  if5  ();

  assign if16.in_valid  = in_valid;
  assign if16.in_data   = in_data;
  assign if16.in_mode   = in_mode;
  assign if16.in_last   = in_last;
  assign if16.out_ready = out_ready;
  assign if13.in_valid  = in_valid;
  assign if13.in_data   = in_data[12:0];
  assign if13.in_mode   = in_mode;
  assign if13.in_last   = in_last;
  assign if13.out_ready = out_ready;
  assign if5.in_valid   = in_valid;
  assign if5.in_data    = in_data;
  assign if5.in_mode    = in_mode;
  assign if5.in_last    = in_last;
  assign if5.out_ready  = out_ready;

  popcount_pipe #(.WIDTH(16), .ACC_W(12)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  popcount_pipe #(.WIDTH(13), .ACC_W(12)) u13 (.clk(clk), .rst_n(rst_n), .bus(if13));
  popcount_pipe #(.WIDTH(16), .ACC_W(5))  u5  (.clk(clk), .rst_n(rst_n), .bus(if5));

  logic ov[3], ir[3], ol[3], os[3];
  int   oc[3], oa[3];

  assign ov[0] = if16.out_valid;  assign ov[1] = if13.out_valid;  assign ov[2] = if5.out_valid;
  assign ir[0] = if16.in_ready;   assign ir[1] = if13.in_ready;   assign ir[2] = if5.in_ready;
  assign ol[0] = if16.out_last;   assign ol[1] = if13.out_last;   assign ol[2] = if5.out_last;
  assign os[0] = if16.out_sat;    assign os[1] = if13.out_sat;    assign os[2] = if5.out_sat;
  assign oc[0] = int'(if16.out_count);
  assign oc[1] = int'(if13.out_count);
  assign oc[2] = int'(if5.out_count);
  assign oa[0] = int'(if16.out_acc);
  assign oa[1] = int'(if13.out_acc);
  assign oa[2] = int'(if5.out_acc);

  function automatic int dut_w(input int d);
    return (d == 1) ? 13 : 16;
  endfunction

  function automatic int dut_max(input int d);
    return (d == 2) ? 31 : 4095;
  endfunction

  function automatic int model_cnt(input int d, input logic [15:0] data, input logic mode);
    logic [15:0] w;
    int m;
    w = mode ? ~data : data;
    m = (1 << dut_w(d)) - 1;
    return $countones(int'(w) & m);
  endfunction

  // Hand-computed results for the directed beats, per instance.
  function automatic lit_t lit_exp(input int d, input int t);
    lit_t r;
    r = '{0, 0, 1'b0, 1'b0};
    case (t)
      0:         r = (d == 1) ? '{13, 13, 1'b0, 1'b1} : '{16, 16, 1'b0, 1'b1};
      1:         r = '{1, 1, 1'b0, 1'b0};
      2:         r = '{8, 9, 1'b0, 1'b0};
      3:         r = (d == 1) ? '{5, 14, 1'b0, 1'b1} : '{8, 17, 1'b0, 1'b1};
      4, 11, 12: r = '{2, 2, 1'b0, 1'b1};
      5:         r = (d == 1) ? '{13, 13, 1'b0, 1'b1} : '{16, 16, 1'b0, 1'b1};
      6:         r = (d == 1) ? '{5, 5, 1'b0, 1'b1} : '{8, 8, 1'b0, 1'b1};
      7:         r = (d == 1) ? '{13, 13, 1'b0, 1'b0} : '{16, 16, 1'b0, 1'b0};
      8:         r = (d == 1) ? '{13, 26, 1'b0, 1'b0} : (d == 2) ? '{16, 31, 1'b1, 1'b0} : '{16, 32, 1'b0, 1'b0};
      9:         r = (d == 1) ? '{13, 39, 1'b0, 1'b0} : (d == 2) ? '{16, 31, 1'b1, 1'b0} : '{16, 48, 1'b0, 1'b0};
      10:        r = (d == 1) ? '{13, 52, 1'b0, 1'b1} : (d == 2) ? '{16, 31, 1'b1, 1'b1} : '{16, 64, 1'b0, 1'b1};
      default:   r = '{0, 0, 1'b0, 1'b0};
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  exp_t mq[3][256];
  int   head[3], tail[3], macc[3];
  bit   msat[3];
  bit   prev_stall[3];
  int   prev_oc[3], prev_oa[3];
  bit   prev_ol[3], prev_os[3];
  bit   prev_rst = 1'b0;

  initial begin
    for (int d = 0; d < 3; d++) begin
      head[d] = 0; tail[d] = 0; macc[d] = 0; msat[d] = 1'b0; prev_stall[d] = 1'b0;
      prev_oc[d] = 0; prev_oa[d] = 0; prev_ol[d] = 1'b0; prev_os[d] = 1'b0;
    end
  end

  // Single compare process: reset values, stall stability, handshake rule and results vs model.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        chk("rst_out_valid", d, int'(ov[d]), 0);
        chk("rst_out_count", d, oc[d], 0);
        chk("rst_out_acc",   d, oa[d], 0);
        chk("rst_out_last",  d, int'(ol[d]), 0);
        chk("rst_out_sat",   d, int'(os[d]), 0);
        chk("rst_in_ready",  d, int'(ir[d]), 0);
        head[d] = tail[d]; macc[d] = 0; msat[d] = 1'b0; prev_stall[d] = 1'b0;
      end
      prev_rst = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (prev_stall[d]) begin
          chk("stall_valid", d, int'(ov[d]), 1);
          chk("stall_count", d, oc[d], prev_oc[d]);
          chk("stall_acc",   d, oa[d], prev_oa[d]);
          chk("stall_last",  d, int'(ol[d]), int'(prev_ol[d]));
          chk("stall_sat",   d, int'(os[d]), int'(prev_os[d]));
        end
        if (prev_rst) chk("in_ready", d, int'(ir[d]), int'(!ov[d] || out_ready));
        if (ov[d] && out_ready) begin
          if (head[d] == tail[d]) begin
            chk("unexpected_result", d, 1, 0);
          end else begin
            exp_t e;
            e = mq[d][head[d] % 256];
            head[d]++;
            chk("count", d, oc[d], e.cnt);
            chk("acc",   d, oa[d], e.acc);
            chk("last",  d, int'(ol[d]), int'(e.last));
            chk("sat",   d, int'(os[d]), int'(e.sat));
            if (e.tag >= 0) begin
              lit_t r;
              r = lit_exp(d, e.tag);
              chk($sformatf("lit%0d_count", e.tag), d, oc[d], r.cnt);
              chk($sformatf("lit%0d_acc",   e.tag), d, oa[d], r.acc);
              chk($sformatf("lit%0d_sat",   e.tag), d, int'(os[d]), int'(r.sat));
              chk($sformatf("lit%0d_last",  e.tag), d, int'(ol[d]), int'(r.last));
              chk($sformatf("lit%0d_latency", e.tag), d, cyc - e.cyc, 5);
            end
          end
        end
        if (in_valid && ir[d]) begin
          int c, s;
          bit hit;
          c   = model_cnt(d, in_data, in_mode);
          s   = macc[d] + c;
          hit = (s > dut_max(d));
          if (hit) s = dut_max(d);
          mq[d][tail[d] % 256] = '{cnt: c, acc: s, last: in_last, sat: (msat[d] || hit), tag: tag, cyc: cyc};
          tail[d]++;
          if (in_last) begin
            macc[d] = 0; msat[d] = 1'b0;
          end else begin
            macc[d] = s; msat[d] = msat[d] || hit;
          end
        end
        prev_stall[d] = ov[d] && !out_ready;
        prev_oc[d] = oc[d]; prev_oa[d] = oa[d]; prev_ol[d] = ol[d]; prev_os[d] = os[d];
      end
      prev_rst = 1'b1;
    end
    if (done) begin
      for (int d = 0; d < 3; d++) chk("drain_pending", d, tail[d] - head[d], 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? ~out_ready : 1'b1;
    end
  end

  task automatic send(input logic [15:0] data, input logic mode, input logic last, input int t);
    int guard;
    in_valid = 1'b1; in_data = data; in_mode = mode; in_last = last; tag = t;
    guard = 0;
    forever begin
      @(negedge clk);
      if (if16.in_ready) break;
      guard++;
      if (guard > 50) begin
        $display("FAIL handshake_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; tag = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_last = 1'b0;
    tag = -1; bp = 1'b0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    send(16'hFFFF, 1'b0, 1'b1, 0);
    idle(8);
    send(16'h0001, 1'b0, 1'b0, 1);
    send(16'h00FF, 1'b0, 1'b0, 2);
    send(16'hF0F0, 1'b0, 1'b1, 3);
    send(16'h0003, 1'b0, 1'b1, 4);
    idle(8);
    send(16'h0000, 1'b1, 1'b1, 5);
    send(16'h00FF, 1'b1, 1'b1, 6);
    idle(8);
    send(16'hFFFF, 1'b0, 1'b0, 7);
    send(16'hFFFF, 1'b0, 1'b0, 8);
    send(16'hFFFF, 1'b0, 1'b0, 9);
    send(16'hFFFF, 1'b0, 1'b1, 10);
    send(16'h0003, 1'b0, 1'b1, 11);
    idle(8);

    bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(16'($urandom), 1'($urandom_range(0, 1)), (i == 9) || ($urandom_range(0, 3) == 0), -1);
    end
    idle(24);
    bp = 1'b0;
    idle(4);

    send(16'h1234, 1'b0, 1'b0, -1);
    send(16'h5678, 1'b0, 1'b0, -1);
    send(16'h9ABC, 1'b1, 1'b0, -1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    send(16'h0003, 1'b0, 1'b1, 12);
    idle(10);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
